addsub_seq: RTL and testbench
=============================

# addsub_seq

Parametrised, multi-cycle integer adder/subtractor that processes a WIDTH-bit operation in CHUNK-bit slices, one slice per clock, with ripple carry held in a register between slices. It generalises the fixed 32-bit single-shot DSP subtractor. It adds an add/sub mode select, carry/zero/signed-overflow flags and valid/ready handshakes on both sides, so that the processor ALU or a coprocessor can share one narrow adder slice (fabric or SB_MAC16) across wide operands.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of CHUNK.
- CHUNK, 16, slice width processed per cycle; NCHUNK = WIDTH/CHUNK (≥1).
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  reset: one clock; reset is synchronous and active-low.
- in_valid  input  1  operands/mode presented.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  first operand (minuend for sub).
- b  input  WIDTH  second operand (subtrahend for sub).
- sub  input  1  0 = a+b, 1 = a−b.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  sum/difference, modulo 2^WIDTH.
- co  output  1  carry out of MSB; for sub, 1 = no borrow (a ≥ b unsigned).
- zero  output  1  result == 0.
- ovf  output  1  signed two's-complement overflow.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: latch a, b (b inverted if sub), sub; carry register ← sub; chunk index ← 0; go BUSY.
- BUSY: each cycle compute slice[idx] = a_slice + b'_slice + carry (CHUNK+1 bits); store low CHUNK bits into result[idx*CHUNK +: CHUNK]; carry ← bit CHUNK; idx++. After slice NCHUNK−1 is stored: co ← final carry, zero and ovf computed from the full result, then go DONE.
- ovf: add → a[MSB]==b[MSB] && result[MSB]!=a[MSB]; sub → a[MSB]!=b[MSB] && result[MSB]!=a[MSB] (original, uninverted b).
- DONE: out_valid=1. result/co/zero/ovf held stable until out_valid&&out_ready, then go IDLE.
- in_ready is 1 only in IDLE. No accept is possible in DONE, even when out_ready=1 in the same cycle.
- Inputs a, b and sub are sampled only on the accepting edge. Later changes have no effect.
- in_valid while not in IDLE is ignored. Upstream must hold it.
- out_ready outside DONE is ignored.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, in_ready=1, out_valid=0, result=0, co=0, zero=0, ovf=0. Reset has priority over all events and aborts BUSY/DONE immediately. Any in-flight result is discarded.
- Latency: accept at edge E. Slices are written at edges E+1 … E+NCHUNK. out_valid=1 from edge E+NCHUNK.
- With out_ready=1 held, DONE lasts one cycle, then IDLE. Minimum issue interval is NCHUNK+2 cycles.
- NCHUNK=1 (CHUNK=WIDTH): single BUSY cycle, out_valid at E+1.
- Outputs are registered. No combinational path from inputs to any output, including in_ready.

## Test plan
- Defaults. Sub a=5, b=3 → result=0x00000002, co=1, zero=0, ovf=0. out_valid rises exactly 2 edges after accept.
- Sub a=3, b=5 → 0xFFFFFFFE, co=0. Sub a=0x80000000, b=1 → 0x7FFFFFFF, ovf=1, co=1.
- Add a=0x0000FFFF, b=1 → 0x00010000, co=0 (inter-slice carry). Add a=0xFFFFFFFF, b=1 → 0, co=1, zero=1. Add a=0x7FFFFFFF, b=1 → 0x80000000, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while toggling a/b/sub/in_valid. Required: result and flags stable, in_ready=0, no second accept. Then out_ready=1 → IDLE next edge.
- Reset mid-op: assert rst_n=0 in BUSY cycle 1 → next edge out_valid=0, in_ready=1, result=0. A fresh op after release completes correctly.
- Reconfigure WIDTH=64, CHUNK=16 and WIDTH=32, CHUNK=32. Run 1000 random add/sub ops against a behavioural model. Check all flags and latency = NCHUNK.

Source files
------------

// File: rtl/addsub_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor that ripples one CHUNK-bit slice per clock.
// The carry is held in a register between slices, so a narrow adder can serve wide operands.
`timescale 1ns/1ps
module addsub_seq #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             co,
   output logic             zero,
   output logic             ovf
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int SW     = CHUNK + 1;
   localparam int MSB    = WIDTH - 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state, state_nx;
   logic [WIDTH-1:0]  a_r, b_r, res_nx;
   logic              carry;
   logic [IDXW-1:0]   idx;
   logic [CHUNK:0]    slice;
   logic              last;
   logic              accept;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = (state == IDLE) && in_valid;
   assign last      = (idx == IDXW'(NCHUNK - 1));

   always_comb begin
      slice  = {1'b0, a_r[int'(idx) * CHUNK +: CHUNK]}
             + {1'b0, b_r[int'(idx) * CHUNK +: CHUNK]}
             + SW'(carry);
      res_nx = result;
      res_nx[int'(idx) * CHUNK +: CHUNK] = slice[CHUNK-1:0];
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid)  state_nx = BUSY;
         BUSY:    if (last)      state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default:                state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_r    <= '0;
         b_r    <= '0;
         carry  <= 1'b0;
         idx    <= '0;
         result <= '0;
         co     <= 1'b0;
         zero   <= 1'b0;
         ovf    <= 1'b0;
      end else if (accept) begin
         a_r   <= a;
         b_r   <= sub ? ~b : b;
         carry <= sub;
         idx   <= '0;
      end else if (state == BUSY) begin
         result <= res_nx;
         carry  <= slice[CHUNK];
         idx    <= idx + 1'b1;
         if (last) begin
            co   <= slice[CHUNK];
            zero <= (res_nx == '0);
            // b_r holds ~b for sub, so one sign test covers both add and sub overflow
            ovf  <= (a_r[MSB] == b_r[MSB]) && (res_nx[MSB] != a_r[MSB]);
         end
      end
   end

endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq: three configurations (32/16, 64/16, 32/32) driven by directed steps
// and random ops; expected results are queued on accept and compared when out_valid appears.
`timescale 1ns/1ps
module tb_addsub_seq;

   typedef struct packed {
      logic [63:0] res;
      logic        co;
      logic        zero;
      logic        ovf;
   } exp_t;

   localparam int NCH [3] = '{2, 4, 1};
   localparam int WD  [3] = '{32, 64, 32};

   logic        clk = 1'b0;
   logic        rst_n;
   logic        iv   [3];
   logic        ordy [3];
   logic        sb_s [3];
   logic [63:0] a_s  [3];
   logic [63:0] b_s  [3];

   logic        ir   [3];
   logic        ov   [3];
   logic        co_s [3];
   logic        z_s  [3];
   logic        of_s [3];
   logic [63:0] res_s[3];

   logic        ir0, ov0, co0, z0, of0;
   logic        ir1, ov1, co1, z1, of1;
   logic        ir2, ov2, co2, z2, of2;
   logic [31:0] r0;
   logic [63:0] r1;
   logic [31:0] r2;

   int   checks = 0;
   int   errors = 0;
   exp_t sbq[$];

   always #5 clk = ~clk;

   addsub_seq #(.WIDTH(32), .CHUNK(16)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir0),
      .a(a_s[0][31:0]), .b(b_s[0][31:0]), .sub(sb_s[0]),
      .out_valid(ov0), .out_ready(ordy[0]), .result(r0),
      .co(co0), .zero(z0), .ovf(of0));

   addsub_seq #(.WIDTH(64), .CHUNK(16)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1),
      .a(a_s[1]), .b(b_s[1]), .sub(sb_s[1]),
      .out_valid(ov1), .out_ready(ordy[1]), .result(r1),
      .co(co1), .zero(z1), .ovf(of1));

   addsub_seq #(.WIDTH(32), .CHUNK(32)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir2),
      .a(a_s[2][31:0]), .b(b_s[2][31:0]), .sub(sb_s[2]),
      .out_valid(ov2), .out_ready(ordy[2]), .result(r2),
      .co(co2), .zero(z2), .ovf(of2));

   assign ir[0] = ir0;  assign ov[0] = ov0;  assign co_s[0] = co0;
   assign z_s[0] = z0;  assign of_s[0] = of0; assign res_s[0] = {32'd0, r0};
   assign ir[1] = ir1;  assign ov[1] = ov1;  assign co_s[1] = co1;
   assign z_s[1] = z1;  assign of_s[1] = of1; assign res_s[1] = r1;
   assign ir[2] = ir2;  assign ov[2] = ov2;  assign co_s[2] = co2;
   assign z_s[2] = z2;  assign of_s[2] = of2; assign res_s[2] = {32'd0, r2};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                  input logic sv);
      exp_t        e;
      logic [64:0] sum;
      logic [63:0] m, am, bm;
      m   = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      am  = av & m;
      bm  = bv & m;
      sum = {1'b0, am} + {1'b0, (sv ? (~bm & m) : bm)} + {64'd0, sv};
      e.res  = sum[63:0] & m;
      e.co   = sum[w];
      e.zero = (e.res == 64'd0);
      if (sv) e.ovf = (am[w-1] != bm[w-1]) && (e.res[w-1] != am[w-1]);
      else    e.ovf = (am[w-1] == bm[w-1]) && (e.res[w-1] != am[w-1]);
      return e;
   endfunction

   function automatic exp_t mk(input logic [63:0] r, input logic c, input logic z, input logic o);
      exp_t e;
      e.res = r; e.co = c; e.zero = z; e.ovf = o;
      return e;
   endfunction

   task automatic pop_cmp(input int k, output exp_t e);
      chk("sb_nonempty", 64'(sbq.size() > 0), 64'd1);
      if (sbq.size() > 0) e = sbq.pop_front();
      else                e = '0;
      chk("result", res_s[k], e.res);
      chk("co",     64'(co_s[k]), 64'(e.co));
      chk("zero",   64'(z_s[k]),  64'(e.zero));
      chk("ovf",    64'(of_s[k]), 64'(e.ovf));
   endtask

   // Accept at edge E, count edges until out_valid, compare, then expect IDLE one edge later.
   task automatic wait_valid(input int k);
      int lat;
      lat = 0;
      while (ov[k] !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", 64'(lat), 64'(NCH[k]));
   endtask

   task automatic run_op(input int k, input logic [63:0] av, input logic [63:0] bv,
                         input logic sv, input exp_t e);
      exp_t got;
      @(negedge clk);
      chk("in_ready_idle", 64'(ir[k]), 64'd1);
      a_s[k] = av; b_s[k] = bv; sb_s[k] = sv; iv[k] = 1'b1; ordy[k] = 1'b1;
      @(posedge clk);
      sbq.push_back(e);
      #1;
      iv[k] = 1'b0; a_s[k] = ~av; b_s[k] = av; sb_s[k] = ~sv;
      wait_valid(k);
      pop_cmp(k, got);
      @(posedge clk); #1;
      chk("back_to_idle", {62'd0, ov[k], ir[k]}, 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t        e, held;
      logic [63:0] av, bv;
      logic        sv;

      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         iv[i] = 1'b0; ordy[i] = 1'b0; sb_s[i] = 1'b0; a_s[i] = '0; b_s[i] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_in_ready",  64'(ir[i]),   64'd1);
         chk("rst_out_valid", 64'(ov[i]),   64'd0);
         chk("rst_result",    res_s[i],     64'd0);
         chk("rst_flags",     {61'd0, co_s[i], z_s[i], of_s[i]}, 64'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      run_op(0, 64'd5,          64'd3, 1'b1, mk(64'h0000_0002, 1'b1, 1'b0, 1'b0));
      run_op(0, 64'd3,          64'd5, 1'b1, mk(64'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
      run_op(0, 64'h8000_0000,  64'd1, 1'b1, mk(64'h7FFF_FFFF, 1'b1, 1'b0, 1'b1));
      run_op(0, 64'h0000_FFFF,  64'd1, 1'b0, mk(64'h0001_0000, 1'b0, 1'b0, 1'b0));
      run_op(0, 64'hFFFF_FFFF,  64'd1, 1'b0, mk(64'h0000_0000, 1'b1, 1'b1, 1'b0));
      run_op(0, 64'h7FFF_FFFF,  64'd1, 1'b0, mk(64'h8000_0000, 1'b0, 1'b0, 1'b1));
      run_op(1, 64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0,
             mk(64'h0001_0000_0000_0000, 1'b0, 1'b0, 1'b0));
      run_op(2, 64'hFFFF_FFFF,  64'd1, 1'b0, mk(64'h0000_0000, 1'b1, 1'b1, 1'b0));

      // Backpressure: result must hold and no new accept while out_ready stays low
      @(negedge clk);
      a_s[0] = 64'h1234_5678; b_s[0] = 64'h1111_1111; sb_s[0] = 1'b0;
      iv[0] = 1'b1; ordy[0] = 1'b0;
      @(posedge clk);
      sbq.push_back(mk(64'h2345_6789, 1'b0, 1'b0, 1'b0));
      #1;
      iv[0] = 1'b0;
      wait_valid(0);
      pop_cmp(0, held);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         a_s[0] = {32'd0, $urandom}; b_s[0] = {32'd0, $urandom};
         sb_s[0] = ~sb_s[0]; iv[0] = ~iv[0];
         @(posedge clk); #1;
         chk("bp_result",    res_s[0], held.res);
         chk("bp_flags",     {61'd0, co_s[0], z_s[0], of_s[0]},
                             {61'd0, held.co, held.zero, held.ovf});
         chk("bp_handshake", {62'd0, ov[0], ir[0]}, 64'd2);
      end
      @(negedge clk);
      iv[0] = 1'b0; ordy[0] = 1'b1;
      @(posedge clk); #1;
      chk("bp_release", {62'd0, ov[0], ir[0]}, 64'd1);
      @(posedge clk); #1;
      chk("bp_no_accept", {62'd0, ov[0], ir[0]}, 64'd1);

      // Reset during the first BUSY cycle discards the operation
      @(negedge clk);
      a_s[0] = 64'hAAAA_5555; b_s[0] = 64'h0F0F_0F0F; sb_s[0] = 1'b1;
      iv[0] = 1'b1; ordy[0] = 1'b1;
      @(posedge clk); #1;
      iv[0] = 1'b0; rst_n = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_out_valid", 64'(ov[0]), 64'd0);
      chk("mid_rst_in_ready",  64'(ir[0]), 64'd1);
      chk("mid_rst_result",    res_s[0],   64'd0);
      chk("mid_rst_co",        64'(co_s[0]), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(0, 64'd5, 64'd3, 1'b1, mk(64'h0000_0002, 1'b1, 1'b0, 1'b0));

      for (int k = 0; k < 3; k++) begin
         for (int n = 0; n < 1000; n++) begin
            av = {$urandom, $urandom};
            bv = {$urandom, $urandom};
            case ($urandom_range(0, 7))
               0: av = '1;
               1: bv = '1;
               2: bv = av;
               3: begin av = 64'h8000_0000_8000_0000; bv = 64'd1; end
               default: ;
            endcase
            sv = 1'($urandom_range(0, 1));
            e  = model(WD[k], av, bv, sv);
            run_op(k, av, bv, sv, e);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
